// File: rtl/serial_block_packer.sv
// -----------------------------------------------------------------------------
// serial_block_packer
//
// Receive side of the interleaver bit-serial link. Two bit-serial streams
// (systematic c_i and interleaved c_pi) for one code block of K_SMALL or
// K_LARGE bits are packed MSB-first into bytes. Each byte pair is presented
// on a valid/ready byte interface together with its index and a last flag.
//
// Ports:
//   clk           system clock, all state on rising edge
//   clear         asynchronous active-high reset
//   k_size_6144   block size select, sampled on accepted start (0=K_SMALL)
//   start         one-cycle pulse opening a new block, honoured only in IDLE
//   bit_in_i      serial bit, systematic stream
//   bit_in_pii    serial bit, interleaved stream
//   bit_valid     bit pair present this cycle
//   bit_ready     packer can take a bit pair this cycle
//   byte_out_i    packed systematic byte, first-received bit in [7]
//   byte_out_pii  packed interleaved byte, first-received bit in [7]
//   byte_valid    byte pair held on outputs
//   byte_ready    downstream accepts byte pair
//   byte_last     final byte of the block (qualified by byte_valid)
//   byte_index    index of held byte within the block
//   block_done    one-cycle pulse after the final byte is accepted
//   busy          high from accepted start until block_done
// -----------------------------------------------------------------------------
module serial_block_packer #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       k_size_6144,
  input  logic       start,
  input  logic       bit_in_i,
  input  logic       bit_in_pii,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] byte_out_i,
  output logic [7:0] byte_out_pii,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic [9:0] byte_index,
  output logic       block_done,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [12:0] K_SMALL_W = 13'(K_SMALL);
  localparam logic [12:0] K_LARGE_W = 13'(K_LARGE);

  logic [1:0]  r_state;
  logic        r_k_sel;
  logic [12:0] r_cnt;
  // Only seven bits are stored: the eighth arrives on the load edge and is
  // concatenated directly into the output holder.
  logic [6:0]  r_acc_i;
  logic [6:0]  r_acc_pii;
  logic [7:0]  r_byte_i;
  logic [7:0]  r_byte_pii;
  logic        r_valid;
  logic        r_last;
  logic [9:0]  r_index;

  logic        w_bit_fire;
  logic        w_byte_fire;
  logic        w_load;
  logic        w_final;
  logic [12:0] w_k;
  logic [12:0] w_cnt_next;

  // Stall whenever a byte would complete while the holder is still occupied,
  // even if it is being accepted this edge; this keeps byte_ready out of the
  // bit_ready path.
  assign bit_ready   = (r_state == S_RECV) && !((r_cnt[2:0] == 3'd7) && r_valid);
  assign w_bit_fire  = bit_valid && bit_ready;
  assign w_byte_fire = r_valid && byte_ready;
  assign w_load      = w_bit_fire && (r_cnt[2:0] == 3'd7);
  assign w_k         = r_k_sel ? K_LARGE_W : K_SMALL_W;
  assign w_cnt_next  = r_cnt + 13'd1;
  assign w_final     = (w_cnt_next == w_k);

  // Control path: state, size select, bit counter and accumulators.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_k_sel   <= 1'b0;
      r_cnt     <= '0;
      r_acc_i   <= '0;
      r_acc_pii <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k_sel   <= k_size_6144;
            r_cnt     <= '0;
            r_acc_i   <= '0;
            r_acc_pii <= '0;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_bit_fire) begin
            r_acc_i   <= {r_acc_i[5:0], bit_in_i};
            r_acc_pii <= {r_acc_pii[5:0], bit_in_pii};
            r_cnt     <= w_cnt_next;
            if (w_final) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_byte_fire) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;  // S_DONE lasts one cycle
      endcase
    end
  end

  // Output holder. A load on the same edge as an accept replaces the held
  // pair without a bubble; an accept alone empties the holder.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_byte_i   <= '0;
      r_byte_pii <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_index    <= '0;
    end else if (w_load) begin
      r_byte_i   <= {r_acc_i, bit_in_i};
      r_byte_pii <= {r_acc_pii, bit_in_pii};
      r_valid    <= 1'b1;
      r_last     <= w_final;
      r_index    <= r_cnt[12:3];
    end else if (w_byte_fire) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign byte_out_i   = r_byte_i;
  assign byte_out_pii = r_byte_pii;
  assign byte_valid   = r_valid;
  assign byte_last    = r_last;
  assign byte_index   = r_index;
  assign block_done   = (r_state == S_DONE);
  assign busy         = (r_state == S_RECV) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_serial_block_packer.sv
module tb_serial_block_packer;

  logic       clk = 1'b0;
  logic       clear;
  logic       k_size_6144;
  logic       start;
  logic       bit_in_i;
  logic       bit_in_pii;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] byte_out_i;
  logic [7:0] byte_out_pii;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic [9:0] byte_index;
  logic       block_done;
  logic       busy;

  always #5 clk = ~clk;

  serial_block_packer dut (
    .clk          (clk),
    .clear        (clear),
    .k_size_6144  (k_size_6144),
    .start        (start),
    .bit_in_i     (bit_in_i),
    .bit_in_pii   (bit_in_pii),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .byte_out_i   (byte_out_i),
    .byte_out_pii (byte_out_pii),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_last    (byte_last),
    .byte_index   (byte_index),
    .block_done   (block_done),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference streams for the current block.
  bit si [6144];
  bit sp [6144];

  function automatic logic [7:0] pack_i(input int n);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = si[8*n+j];
    return b;
  endfunction

  function automatic logic [7:0] pack_p(input int n);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = sp[8*n+j];
    return b;
  endfunction

  // dmode 0: 0xB2 on both, 1: byte counter on i / inverted on pii, 2: random
  task automatic gen(input int k, input int dmode);
    logic [7:0] pat;
    logic [7:0] c;
    pat = 8'hB2;
    for (int n = 0; n < k; n++) begin
      c = 8'(n / 8);
      case (dmode)
        0: begin si[n] = pat[7 - n%8]; sp[n] = pat[7 - n%8]; end
        1: begin si[n] = c[7 - n%8];   sp[n] = ~c[7 - n%8]; end
        default: begin si[n] = 1'($urandom); sp[n] = 1'($urandom); end
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_ready"},  bit_ready,    0);
    check({tag, "_byte_valid"}, byte_valid,   0);
    check({tag, "_byte_last"},  byte_last,    0);
    check({tag, "_byte_index"}, byte_index,   0);
    check({tag, "_block_done"}, block_done,   0);
    check({tag, "_busy"},       busy,         0);
    check({tag, "_byte_i"},     byte_out_i,   0);
    check({tag, "_byte_pii"},   byte_out_pii, 0);
  endtask

  // Runs one block from IDLE. Called and returns at posedge+#1.
  // bvmode: 0 continuous, 1 toggling, 2 random bit_valid
  // brmode: 0 always ready, 1 stall after first byte, 2 random byte_ready
  // ctl: pulse start and flip k_size_6144 mid-block
  // abort_at: assert clear once this many bits were taken (-1 = never)
  task automatic run_block(input bit kl, input int dmode, input int bvmode,
                           input int brmode, input bit ctl, input int abort_at);
    int  k;
    int  nb;
    int  sent;
    int  acc;
    int  cyc;
    int  first_v;
    int  stalls;
    bit  exp_valid;
    bit  exp_ready;
    bit  bv;
    bit  br;
    k       = kl ? 6144 : 1056;
    nb      = k / 8;
    sent    = 0;
    acc     = 0;
    first_v = -1;
    stalls  = 0;
    gen(k, dmode);

    // bit_valid rides along with start; IDLE must ignore it.
    start       = 1'b1;
    k_size_6144 = kl;
    bit_valid   = (bvmode == 0);
    bit_in_i    = si[0];
    bit_in_pii  = sp[0];
    byte_ready  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;

    forever begin
      if (abort_at >= 0 && sent == abort_at) begin
        clear = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        clear     = 1'b0;
        bit_valid = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("abort_no_done", block_done, 0);
          check("abort_idle_busy", busy, 0);
        end
        return;
      end

      if (acc == nb) begin
        check("done_pulse", block_done, 1);
        check("done_busy", busy, 0);
        check("done_valid", byte_valid, 0);
        bit_valid = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", block_done, 0);
        check("idle_busy", busy, 0);
        if (brmode == 1) check("stall_seen", (stalls > 0), 1);
        return;
      end

      exp_valid = (sent / 8) > acc;
      exp_ready = (sent < k) && !((sent % 8 == 7) && exp_valid);
      check("busy", busy, 1);
      check("block_done_low", block_done, 0);
      check("bit_ready", bit_ready, exp_ready);
      check("byte_valid", byte_valid, exp_valid);
      if (!bit_ready && sent < k) stalls++;
      if (exp_valid) begin
        check("byte_i", byte_out_i, pack_i(acc));
        check("byte_pii", byte_out_pii, pack_p(acc));
        check("byte_index", byte_index, acc);
        check("byte_last", byte_last, (acc == nb - 1));
        if (first_v < 0) begin
          first_v = cyc;
          if (bvmode == 0) check("first_latency", first_v, 9);
        end
      end

      case (bvmode)
        0: bv = 1'b1;
        1: bv = (cyc % 2 == 0);
        default: bv = 1'($urandom);
      endcase
      case (brmode)
        0: br = 1'b1;
        1: br = (acc == 0) || (cyc >= 150);
        default: br = 1'($urandom);
      endcase
      bit_valid  = bv;
      byte_ready = br;
      bit_in_i   = (sent < k) ? si[sent] : 1'($urandom);
      bit_in_pii = (sent < k) ? sp[sent] : 1'($urandom);
      start      = ctl && (cyc == 200);
      if (ctl && cyc >= 100) k_size_6144 = ~kl;

      if (bv && exp_ready) sent++;
      if (exp_valid && br) acc++;

      @(posedge clk); #1;
      cyc++;
      if (cyc > 40000) begin
        check("block_timeout", cyc, 0);
        return;
      end
    end
  endtask

  initial begin
    clear       = 1'b1;
    k_size_6144 = 1'b0;
    start       = 1'b0;
    bit_in_i    = 1'b0;
    bit_in_pii  = 1'b0;
    bit_valid   = 1'b0;
    byte_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clear = 1'b0;

    // bit_valid while IDLE produces nothing.
    for (int i = 0; i < 20; i++) begin
      bit_valid  = 1'b1;
      bit_in_i   = 1'($urandom);
      bit_in_pii = 1'($urandom);
      @(posedge clk); #1;
      check("idle_byte_valid", byte_valid, 0);
      check("idle_bit_ready", bit_ready, 0);
      check("idle_busy", busy, 0);
    end
    bit_valid = 1'b0;

    run_block(1'b0, 0, 0, 0, 1'b0, -1);  // 1056, 0xB2, no backpressure
    run_block(1'b1, 1, 0, 0, 1'b0, -1);  // 6144, counter / inverted
    run_block(1'b0, 0, 0, 1, 1'b0, -1);  // backpressure
    run_block(1'b0, 0, 1, 0, 1'b0, -1);  // gapped input
    run_block(1'b0, 2, 2, 2, 1'b1, -1);  // random, control edges
    run_block(1'b1, 2, 2, 2, 1'b1, -1);  // random large, control edges
    run_block(1'b1, 2, 0, 0, 1'b0, 500); // clear mid-block
    run_block(1'b1, 1, 2, 2, 1'b0, -1);  // fresh block after clear

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
